// File: rtl/booth_divider_if.sv
// Start/ready handshake bundle shared by the divider and its sequencer.
// Operands flow master->slave; results and status flow back.
interface booth_divider_if #(
    parameter int N = 6
);
    logic              start;
    logic [2*N-1:0]    dividend;
    logic [N-1:0]      divisor;
    logic              ready;
    logic              done;
    logic [2*N-1:0]    quotient;
    logic [N-1:0]      remainder;
    logic              div_by_zero;
    logic              overflow;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/booth_divider.sv
// Sequential signed divider: 2N-bit dividend / N-bit divisor, restoring
// division on magnitudes (one quotient bit per clock) followed by a sign fix-up.
module booth_divider #(
    parameter int N = 6
) (
    input  logic           clk,
    input  logic           rst,
    booth_divider_if.slave bus
);
    localparam int W  = 2 * N;
    localparam int CW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  dvd_r;
    logic [N-1:0]  dsor_r;
    logic [W-1:0]  qreg_r;
    logic [N-1:0]  prem_r;
    logic [N:0]    dmag_r;
    logic          sign_q_r;
    logic          sign_r_r;
    logic          ready_r;
    logic          done_r;
    logic [W-1:0]  quot_r;
    logic [N-1:0]  rem_r;
    logic          dz_r;
    logic          ovf_r;

    logic [W-1:0]  dvd_mag_s;
    logic [N:0]    dsor_ext_s;
    logic [N:0]    dsor_mag_s;
    logic [N:0]    shifted_s;
    logic          ge_s;
    logic [N-1:0]  diff_s;
    logic [W-1:0]  qfix_s;
    logic [N-1:0]  rfix_s;
    logic          ovf_s;
    logic          dz_s;

    // Operand magnitudes, one restoring-division step and the signed fix-up values.
    always_comb begin
        dvd_mag_s  = dvd_r[W-1] ? -dvd_r : dvd_r;
        dsor_ext_s = {dsor_r[N-1], dsor_r};
        dsor_mag_s = dsor_r[N-1] ? -dsor_ext_s : dsor_ext_s;
        shifted_s  = {prem_r, qreg_r[W-1]};
        ge_s       = (shifted_s >= dmag_r);
        // Any kept difference is below |divisor| <= 2^(N-1), so N bits suffice.
        diff_s     = shifted_s[N-1:0] - dmag_r[N-1:0];
        qfix_s     = sign_q_r ? -qreg_r : qreg_r;
        rfix_s     = sign_r_r ? -prem_r : prem_r;
        dz_s       = (dsor_r == {N{1'b0}});
        ovf_s      = (dvd_r == {1'b1, {(W-1){1'b0}}}) && (dsor_r == {N{1'b1}});
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            cnt_r    <= '0;
            dvd_r    <= '0;
            dsor_r   <= '0;
            qreg_r   <= '0;
            prem_r   <= '0;
            dmag_r   <= '0;
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            quot_r   <= '0;
            rem_r    <= '0;
            dz_r     <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        dvd_r   <= bus.dividend;
                        dsor_r  <= bus.divisor;
                        dz_r    <= 1'b0;
                        ovf_r   <= 1'b0;
                        ready_r <= 1'b0;
                        state_r <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sign_q_r <= dvd_r[W-1] ^ dsor_r[N-1];
                    sign_r_r <= dvd_r[W-1];
                    qreg_r   <= dvd_mag_s;
                    dmag_r   <= dsor_mag_s;
                    prem_r   <= '0;
                    cnt_r    <= '0;
                    state_r  <= dz_s ? S_FIX : S_ITER;
                end
                S_ITER: begin
                    prem_r <= ge_s ? diff_s : shifted_s[N-1:0];
                    qreg_r <= {qreg_r[W-2:0], ge_s};
                    cnt_r  <= cnt_r + CW'(1);
                    if (cnt_r == CW'(W - 1)) begin
                        state_r <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (dz_s) begin
                        quot_r <= '0;
                        rem_r  <= '0;
                        dz_r   <= 1'b1;
                        ovf_r  <= 1'b0;
                    end else begin
                        // The most-negative / -1 case wraps naturally to -2^(2N-1).
                        quot_r <= qfix_s;
                        rem_r  <= rfix_s;
                        dz_r   <= 1'b0;
                        ovf_r  <= ovf_s;
                    end
                    done_r  <= 1'b1;
                    ready_r <= 1'b1;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready       = ready_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dz_r;
    assign bus.overflow    = ovf_r;
endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider: directed cases, then random operands
// compared with an integer-arithmetic reference model.
module tb_booth_divider;
    localparam int N = 6;

    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   miss = 0;
    logic [11:0] prev_q;

    always #5 clk = ~clk;

    booth_divider_if #(.N(N)) bus ();
    booth_divider #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed integer division (truncating toward zero).
    task automatic model(input int a, input int b, output logic [11:0] q,
                         output logic [5:0] r, output logic dz, output logic ovf,
                         output int lat);
        int qi;
        int ri;
        if (b == 0) begin
            q = 12'd0; r = 6'd0; dz = 1'b1; ovf = 1'b0; lat = 2;
        end else begin
            qi  = a / b;
            ri  = a % b;
            q   = qi[11:0];
            r   = ri[5:0];
            dz  = 1'b0;
            ovf = (a == -2048) && (b == -1);
            lat = 14;
        end
    endtask

    task automatic start_op(input int a, input int b);
        bus.dividend = a[11:0];
        bus.divisor  = b[5:0];
        bus.start    = 1'b1;
        tick;
        bus.start    = 1'b0;
        bus.dividend = 12'($urandom);
        bus.divisor  = 6'($urandom);
        chk("ready_low", {31'd0, bus.ready}, 32'd0);
        chk("dz_clear", {31'd0, bus.div_by_zero}, 32'd0);
        chk("ovf_clear", {31'd0, bus.overflow}, 32'd0);
        chk("q_hold_at_start", {20'd0, bus.quotient}, {20'd0, prev_q});
    endtask

    task automatic finish_op(input int a, input int b, input int lat0);
        int lat;
        int elat;
        logic [11:0] eq;
        logic [5:0]  er;
        logic edz;
        logic eovf;
        lat = lat0;
        while (bus.done !== 1'b1 && lat < 40) begin
            tick;
            lat++;
        end
        model(a, b, eq, er, edz, eovf, elat);
        chk("latency", lat, elat);
        chk("quotient", {20'd0, bus.quotient}, {20'd0, eq});
        chk("remainder", {26'd0, bus.remainder}, {26'd0, er});
        chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, edz});
        chk("overflow", {31'd0, bus.overflow}, {31'd0, eovf});
        chk("ready_back", {31'd0, bus.ready}, 32'd1);
        prev_q = eq;
        tick;
        chk("done_single", {31'd0, bus.done}, 32'd0);
        chk("q_hold_after", {20'd0, bus.quotient}, {20'd0, eq});
    endtask

    task automatic run(input int a, input int b);
        start_op(a, b);
        finish_op(a, b, 0);
    endtask

    initial begin
        int lat;
        int ndone;
        int last;
        logic [11:0] a12;
        logic [5:0]  b6;
        int ai;
        int bi;

        bus.start = 1'b0;
        bus.dividend = 12'd0;
        bus.divisor = 6'd0;
        rst = 1'b1;
        tick;
        tick;
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_q", {20'd0, bus.quotient}, 32'd0);
        chk("rst_r", {26'd0, bus.remainder}, 32'd0);
        chk("rst_flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
        rst = 1'b0;
        prev_q = 12'd0;
        tick;
        chk("idle_ready", {31'd0, bus.ready}, 32'd1);

        // Directed cases from the plan.
        run(91, 7);
        run(-100, 7);
        run(100, -32);
        run(-2048, -1);
        run(55, 0);
        run(2047, 1);

        // A start while busy is ignored.
        start_op(91, 7);
        lat = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            lat++;
        end
        bus.dividend = 12'd100;
        bus.divisor = 6'd3;
        bus.start = 1'b1;
        tick;
        lat++;
        bus.start = 1'b0;
        chk("busy_ready", {31'd0, bus.ready}, 32'd0);
        finish_op(91, 7, lat);

        // Reset in flight aborts and clears everything.
        start_op(1000, -9);
        for (int i = 0; i < 6; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_q", {20'd0, bus.quotient}, 32'd0);
        chk("mid_rst_r", {26'd0, bus.remainder}, 32'd0);
        chk("mid_rst_flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
        prev_q = 12'd0;
        tick;
        chk("mid_rst_idle", {31'd0, bus.ready}, 32'd1);
        run(20, 3);

        // start held high: back-to-back operations 15 cycles apart.
        bus.dividend = 12'(-2047);
        bus.divisor = 6'd31;
        bus.start = 1'b1;
        tick;
        ndone = 0;
        last = 0;
        for (int c = 1; c <= 44; c++) begin
            tick;
            if (bus.done === 1'b1) begin
                chk("held_spacing", c - last, (ndone == 0) ? 14 : 15);
                chk("held_q", {20'd0, bus.quotient}, 32'hFBE);
                chk("held_r", {26'd0, bus.remainder}, 32'h3F);
                last = c;
                ndone++;
            end
        end
        chk("held_count", ndone, 3);
        bus.start = 1'b0;
        tick;
        chk("held_done_drop", {31'd0, bus.done}, 32'd0);
        for (int i = 0; i < 20; i++) tick;
        prev_q = 12'hFBE;
        chk("held_final_q", {20'd0, bus.quotient}, 32'hFBE);

        // Random operands with periodic boundary cases.
        for (int i = 0; i < 60; i++) begin
            a12 = 12'($urandom);
            b6  = 6'($urandom);
            ai  = $signed(a12);
            bi  = $signed(b6);
            if (i % 10 == 3) bi = 0;
            if (i == 5) begin ai = -2048; bi = -1; end
            if (i == 15) begin ai = 2047; bi = -32; end
            if (i == 25) begin ai = -2048; bi = -32; end
            if (i == 35) begin ai = -2048; bi = 1; end
            run(ai, bi);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
